// File: rtl/pattern_seq_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, PAT_MAX_W helper width, pat_match() compare.
package pattern_seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Widest pattern pat_match() can compare; callers zero-extend narrower
  // operands, and the zeroed mask bits make the extension harmless.
  localparam int PAT_MAX_W = 32;

  // True when every masked bit of the window equals the pattern.
  function automatic logic pat_match(input logic [PAT_MAX_W-1:0] shreg,
                                     input logic [PAT_MAX_W-1:0] pattern,
                                     input logic [PAT_MAX_W-1:0] mask);
    return ((shreg ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/pattern_seq_detector_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Latency: 1 cycle from inc_i/clr_i to cnt_o.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk_i, reset_i (sync, active-high), inc_i, clr_i, cnt_o[COUNT_W-1:0].
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [COUNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_seq_detector.sv
// Maskable, runtime-loadable serial pattern detector with a saturating match counter.
// Latency: detected_o pulses for one cycle, registered off the accepting edge.
// Backpressure: none; samples arriving while idle or during cfg_load_i are dropped.
// Ports: clk_i, reset_i (sync, active-high), enable_i, in_valid_i, in_i, cfg_load_i,
//        pattern_i, mask_i, overlap_i, cnt_clr_i -> detected_o, match_cnt_o, busy_o.
module pattern_seq_detector
  import pattern_seq_detector_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter int                   COUNT_W   = 16,
  parameter logic [PATTERN_W-1:0] RST_PAT   = PATTERN_W'(4'hB)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 in_valid_i,
  input  logic                 in_i,
  input  logic                 cfg_load_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [PATTERN_W-1:0] mask_i,
  input  logic                 overlap_i,
  input  logic                 cnt_clr_i,
  output logic                 detected_o,
  output logic [COUNT_W-1:0]   match_cnt_o,
  output logic                 busy_o
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  state_t               state, state_nxt;
  logic [PATTERN_W-1:0] shreg, shreg_nxt, shifted;
  logic [FILL_W-1:0]    fill, fill_nxt, fill_inc;
  logic [PATTERN_W-1:0] pattern, mask;
  logic                 overlap;
  logic                 match;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    fill_nxt  = fill;
    match     = 1'b0;
    shifted   = {shreg[PATTERN_W-2:0], in_i};
    fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);

    if (cfg_load_i) begin
      // New configuration starts from an empty window; the concurrent sample is discarded.
      shreg_nxt = '0;
      fill_nxt  = '0;
      state_nxt = enable_i ? FILL : IDLE;
    end else if (!enable_i) begin
      shreg_nxt = '0;
      fill_nxt  = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = FILL;
        default: begin
          if (in_valid_i) begin
            shreg_nxt = shifted;
            fill_nxt  = fill_inc;
            if (fill_inc == FILL_FULL) begin
              match = pat_match(PAT_MAX_W'(shifted), PAT_MAX_W'(pattern), PAT_MAX_W'(mask));
              // Non-overlapping mode restarts the fill so the next hit needs a full fresh window.
              if (match && !overlap) begin
                fill_nxt  = '0;
                state_nxt = FILL;
              end else begin
                state_nxt = RUN;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      shreg      <= '0;
      fill       <= '0;
      pattern    <= RST_PAT;
      mask       <= '1;
      overlap    <= 1'b1;
      detected_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      fill       <= fill_nxt;
      detected_o <= match;
      // Tracks the registered state so busy_o == (state != IDLE) every cycle.
      busy_o     <= (state_nxt != IDLE);
      if (cfg_load_i) begin
        pattern <= pattern_i;
        mask    <= mask_i;
        overlap <= overlap_i;
      end
    end
  end

  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (match),
    .clr_i   (cnt_clr_i),
    .cnt_o   (match_cnt_o)
  );

endmodule
